// File: rtl/eqa_pkg.sv
// Shared types and helpers for the multiband equaliser combiner:
// FSM state encoding, gain/accumulator sizing and output saturation.
package eqa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACC,
        S_OUT
    } state_t;

    function automatic int unity_gain(input int frac);
        return 1 << frac;
    endfunction

    function automatic int acc_width(input int sw, input int gw, input int nb);
        return sw + gw + $clog2(nb);
    endfunction

    // Clamp a sign-extended value to the signed range of an sw-bit sample.
    function automatic logic signed [63:0] sat_sw(input logic signed [63:0] v, input int sw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (sw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (sw - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/eqa_band_capture.sv
// One band's capture slot: keeps the first output strobe of the current
// sample and flags it as done; later strobes are ignored until cleared.
module eqa_band_capture import eqa_pkg::*; #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic                i_valid,
    input  logic [SAMPLE_W-1:0] i_data,
    output logic [SAMPLE_W-1:0] o_data,
    output logic                o_done
);

    logic [SAMPLE_W-1:0] r_data;
    logic                r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_done <= 1'b0;
        end else if (i_clr) begin
            r_data <= '0;
            r_done <= 1'b0;
        end else if (i_en && i_valid && !r_done) begin
            r_data <= i_data;
            r_done <= 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_done = r_done;

endmodule

// File: rtl/eqa_multiband.sv
// Multiband equaliser combiner: fans one sample out to NUM_BANDS filters, gathers
// their outputs, gain-weights them through a serial MAC and saturates the sum.
// Optional clip counter port/logic is built when EQA_CLIP_CNT_EN is defined.
module eqa_multiband import eqa_pkg::*; #(
    parameter int SAMPLE_W    = 16,
    parameter int NUM_BANDS   = 5,
    parameter int GAIN_W      = 8,
    parameter int GAIN_FRAC   = 6,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SAMPLE_W-1:0]           in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_BANDS*GAIN_W-1:0]   gain,
    input  logic [NUM_BANDS-1:0]          band_ready,
    output logic [NUM_BANDS-1:0]          band_inpvalid,
    output logic [SAMPLE_W-1:0]           band_din,
    input  logic [NUM_BANDS-1:0]          band_outvalid,
    input  logic [NUM_BANDS*SAMPLE_W-1:0] band_dout,
    output logic [SAMPLE_W-1:0]           out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef EQA_CLIP_CNT_EN
    output logic [15:0]                   clip_cnt,
`endif
    output logic                          timeout_err
);

    localparam int ACC_W  = acc_width(SAMPLE_W, GAIN_W, NUM_BANDS);
    localparam int PROD_W = SAMPLE_W + GAIN_W;
    localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t                    r_state;
    logic                      r_alive;
    logic [NUM_BANDS-1:0]      r_inpvalid;
    logic [SAMPLE_W-1:0]       r_din;
    logic [TO_W-1:0]           r_to_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic [SAMPLE_W-1:0]       r_out_data;
    logic                      r_out_valid;
    logic                      r_timeout_err;

    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_all_done;
    logic                      w_last;
    logic [NUM_BANDS-1:0]      w_done;
    logic signed [SAMPLE_W-1:0] w_cap [NUM_BANDS];
    logic signed [SAMPLE_W-1:0] w_cap_sel;
    logic signed [GAIN_W-1:0]  w_gain_sel;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W-1:0]   w_shift;

    // r_alive keeps in_ready low while reset is held and for the release cycle.
    assign w_in_ready = (r_state == S_IDLE) && r_alive && (&band_ready);
    assign w_accept   = w_in_ready && in_valid;

    generate
        for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_band
            eqa_band_capture #(.SAMPLE_W(SAMPLE_W)) u_cap (
                .clk     (clk),
                .reset   (reset),
                .i_clr   (w_accept),
                .i_en    (r_state == S_WAIT),
                .i_valid (band_outvalid[gi]),
                .i_data  (band_dout[gi*SAMPLE_W +: SAMPLE_W]),
                .o_data  (w_cap[gi]),
                .o_done  (w_done[gi])
            );
        end
    endgenerate

    // Bands strobing this cycle count as done so a same-cycle finish moves on at once.
    assign w_all_done = &(w_done | band_outvalid);
    assign w_last     = (r_idx == IDX_W'(NUM_BANDS - 1));

    assign w_cap_sel  = w_cap[r_idx];
    assign w_gain_sel = $signed(gain[r_idx*GAIN_W +: GAIN_W]);
    assign w_prod     = PROD_W'(w_cap_sel) * PROD_W'(w_gain_sel);
    assign w_acc_next = r_acc + ACC_W'(w_prod);
    assign w_shift    = w_acc_next >>> GAIN_FRAC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_alive       <= 1'b0;
            r_inpvalid    <= '0;
            r_din         <= '0;
            r_to_cnt      <= '0;
            r_idx         <= '0;
            r_acc         <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_alive       <= 1'b1;
            r_inpvalid    <= '0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_din      <= in_data;
                        r_to_cnt   <= '0;
                        r_idx      <= '0;
                        r_acc      <= '0;
                        r_inpvalid <= '1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (w_all_done) begin
                        r_state <= S_ACC;
                    end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_out_data  <= SAMPLE_W'(sat_sw(64'(w_shift), SAMPLE_W));
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef EQA_CLIP_CNT_EN
    logic [15:0] r_clip_cnt;
    logic        w_clip;

    assign w_clip = (sat_sw(64'(w_shift), SAMPLE_W) != 64'(w_shift));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_clip_cnt <= '0;
        else if (r_state == S_ACC && w_last && w_clip && r_clip_cnt != 16'hFFFF)
            r_clip_cnt <= r_clip_cnt + 16'd1;
    end

    assign clip_cnt = r_clip_cnt;
`endif

    assign in_ready      = w_in_ready;
    assign band_inpvalid = r_inpvalid;
    assign band_din      = r_din;
    assign out_data      = r_out_data;
    assign out_valid     = r_out_valid;
    assign timeout_err   = r_timeout_err;

endmodule
